vec_response_checker: RTL and testbench

- Sequential stimulus/response harness controller for the team's 50-in/30-out combinational DUT blocks.
- Holds a bank of stimulus vectors with matching golden result vectors. It drives each stimulus onto the DUT input, waits a settle interval, captures the DUT output and compares it against the golden vector.
- Replaces file-based write-out of a single result with on-chip replay of many vectors, with readback of every captured result and a mismatch summary.

---
 rtl/vec_response_checker.sv | 209 ++++++++++++++++++++
 tb/tb_vec_response_checker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_response_checker.sv
// Stimulus/response replay controller: drives stored vectors into a combinational DUT,
// captures each result after a settle interval and compares it against a golden vector.
module vec_response_checker #(
    parameter int unsigned IN_W   = 50,
    parameter int unsigned OUT_W  = 30,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ld_we,
    input  logic [AW-1:0]    i_ld_addr,
    input  logic [IN_W-1:0]  i_ld_stim,
    input  logic [OUT_W-1:0] i_ld_gold,
    input  logic             i_start,
    input  logic [AW:0]      i_num_vec,
    output logic [IN_W-1:0]  o_dut_in,
    input  logic [OUT_W-1:0] i_dut_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [AW:0]      o_mismatch_cnt,
    output logic [AW-1:0]    o_first_fail_idx,
    output logic             o_first_fail_vld,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [OUT_W-1:0] o_rd_data
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWait,
        StCapture,
        StFinish
    } state_t;

    // Vector banks; deliberately not reset so a reset never loses loaded vectors.
    logic [IN_W-1:0]  r_stim [DEPTH];
    logic [OUT_W-1:0] r_gold [DEPTH];
    logic [OUT_W-1:0] r_res  [DEPTH];

    state_t           r_state;
    logic [AW-1:0]    r_idx;
    logic [AW:0]      r_num;
    logic [SW-1:0]    r_settle;
    logic [IN_W-1:0]  r_dut_in;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [AW:0]      r_mm_cnt;
    logic [AW-1:0]    r_ff_idx;
    logic             r_ff_vld;
    logic [OUT_W-1:0] r_rd_data;

    state_t           w_state_nxt;
    logic [AW-1:0]    w_idx_nxt;
    logic [AW:0]      w_num_nxt;
    logic [SW-1:0]    w_settle_nxt;
    logic [IN_W-1:0]  w_dut_in_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic [AW:0]      w_mm_cnt_nxt;
    logic [AW-1:0]    w_ff_idx_nxt;
    logic             w_ff_vld_nxt;

    logic             w_start_ok;
    logic             w_last;
    logic             w_miss;
    logic             w_ld_en;
    logic             w_cap_en;

    assign w_start_ok = (i_num_vec != '0) && (i_num_vec <= DEPTH_W);
    assign w_last     = ({1'b0, r_idx} == (r_num - (AW+1)'(1)));
    assign w_miss     = (i_dut_out != r_gold[r_idx]);
    assign w_ld_en    = (r_state == StIdle) && i_ld_we;
    assign w_cap_en   = (r_state == StCapture);

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_num_nxt    = r_num;
        w_settle_nxt = r_settle;
        w_dut_in_nxt = r_dut_in;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_pass_nxt   = r_pass;
        w_mm_cnt_nxt = r_mm_cnt;
        w_ff_idx_nxt = r_ff_idx;
        w_ff_vld_nxt = r_ff_vld;

        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_pass_nxt   = 1'b0;
                    w_mm_cnt_nxt = '0;
                    w_ff_vld_nxt = 1'b0;
                    if (w_start_ok) begin
                        w_num_nxt   = i_num_vec;
                        w_idx_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = StDrive;
                    end else begin
                        // Illegal vector count: report an empty, failing run at once.
                        w_done_nxt = 1'b1;
                    end
                end
            end

            StDrive: begin
                w_dut_in_nxt = r_stim[r_idx];
                w_settle_nxt = SW'(SETTLE - 1);
                w_state_nxt  = StWait;
            end

            StWait: begin
                if (r_settle == '0) begin
                    w_state_nxt = StCapture;
                end else begin
                    w_settle_nxt = r_settle - SW'(1);
                end
            end

            StCapture: begin
                if (w_miss) begin
                    if (r_mm_cnt != DEPTH_W) begin
                        w_mm_cnt_nxt = r_mm_cnt + (AW+1)'(1);
                    end
                    if (!r_ff_vld) begin
                        w_ff_idx_nxt = r_idx;
                        w_ff_vld_nxt = 1'b1;
                    end
                end
                if (w_last) begin
                    w_state_nxt = StFinish;
                end else begin
                    w_idx_nxt   = r_idx + AW'(1);
                    w_state_nxt = StDrive;
                end
            end

            StFinish: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_pass_nxt  = (r_mm_cnt == '0);
                w_state_nxt = StIdle;
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_idx     <= '0;
            r_num     <= '0;
            r_settle  <= '0;
            r_dut_in  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_mm_cnt  <= '0;
            r_ff_idx  <= '0;
            r_ff_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_num     <= w_num_nxt;
            r_settle  <= w_settle_nxt;
            r_dut_in  <= w_dut_in_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_pass    <= w_pass_nxt;
            r_mm_cnt  <= w_mm_cnt_nxt;
            r_ff_idx  <= w_ff_idx_nxt;
            r_ff_vld  <= w_ff_vld_nxt;
            // Read-before-write: a same-cycle capture to rd_addr is seen next cycle.
            r_rd_data <= r_res[i_rd_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_ld_en) begin
            r_stim[i_ld_addr] <= i_ld_stim;
            r_gold[i_ld_addr] <= i_ld_gold;
        end
        if (w_cap_en) begin
            r_res[r_idx] <= i_dut_out;
        end
    end

    assign o_dut_in         = r_dut_in;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_mismatch_cnt   = r_mm_cnt;
    assign o_first_fail_idx = r_ff_idx;
    assign o_first_fail_vld = r_ff_vld;
    assign o_rd_data        = r_rd_data;

endmodule

// File: tb/tb_vec_response_checker.sv
// Directed bench for vec_response_checker: one SETTLE=2 instance under full test and a
// SETTLE=3 instance sharing its inputs for the DUT-input stability scenario.
module tb_vec_response_checker;

    logic        clk = 1'b0;
    logic        rst, ld_we, start, model_zero;
    logic [3:0]  ld_addr, rd_addr;
    logic [49:0] ld_stim;
    logic [29:0] ld_gold;
    logic [4:0]  num_vec;

    logic [49:0] dut_in_a, dut_in_b;
    logic [29:0] dut_out_a, dut_out_b, rd_data_a, rd_data_b;
    logic        busy_a, done_a, pass_a, ffv_a, busy_b, done_b, pass_b, ffv_b;
    logic [4:0]  mm_a, mm_b;
    logic [3:0]  ffi_a, ffi_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic [49:0] stim_tab [16];
    logic [29:0] gold_tab [16];

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational block under test.
    function automatic logic [29:0] model_f(input logic [49:0] x);
        return x[29:0] + x[49:20];
    endfunction

    assign dut_out_a = model_zero ? 30'h0 : model_f(dut_in_a);
    assign dut_out_b = model_zero ? 30'h0 : model_f(dut_in_b);

    vec_response_checker #(.SETTLE(2)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_stim(ld_stim),
        .i_ld_gold(ld_gold), .i_start(start), .i_num_vec(num_vec), .o_dut_in(dut_in_a),
        .i_dut_out(dut_out_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
        .o_mismatch_cnt(mm_a), .o_first_fail_idx(ffi_a), .o_first_fail_vld(ffv_a),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data_a)
    );

    vec_response_checker #(.SETTLE(3)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_stim(ld_stim),
        .i_ld_gold(ld_gold), .i_start(start), .i_num_vec(num_vec), .o_dut_in(dut_in_b),
        .i_dut_out(dut_out_b), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
        .o_mismatch_cnt(mm_b), .o_first_fail_idx(ffi_b), .o_first_fail_vld(ffv_b),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_slot(input logic [3:0] a, input logic [49:0] s, input logic [29:0] g);
        ld_we = 1'b1; ld_addr = a; ld_stim = s; ld_gold = g;
        step();
        ld_we = 1'b0;
    endtask

    // lat = edges after the start edge until done is seen; busy_cnt = cycles busy observed.
    task automatic start_and_wait(input logic [4:0] n, output int lat, output int busy_cnt);
        start = 1'b1; num_vec = n;
        step();
        start = 1'b0;
        lat = 0;
        busy_cnt = busy_a ? 1 : 0;
        while (!done_a && lat < 300) begin
            step();
            lat++;
            if (busy_a) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_we = 1'b0; start = 1'b0; ld_addr = '0; rd_addr = '0;
        ld_stim = '0; ld_gold = '0; num_vec = '0; model_zero = 1'b1;
        idle(2);
        rst = 1'b0;
        n_tests++;
        if ({busy_a, done_a, pass_a, ffv_a} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {busy_a, done_a, pass_a, ffv_a});
        end
        n_tests++;
        if (dut_in_a !== 50'h0) begin
            n_fail++; $display("FAIL reset_dut_in: got %h want 0", dut_in_a);
        end
        n_tests++;
        if ({mm_a, ffi_a} !== 9'h0) begin
            n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", mm_a, ffi_a);
        end
        n_tests++;
        if (rd_data_a !== 30'h0) begin
            n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data_a);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        model_zero = 1'b1;
        load_slot(4'd0, 50'h1_0000_0000, 30'h0);
        start_and_wait(5'd1, lat, bc);
        n_tests++;
        if (lat != 5) begin n_fail++; $display("FAIL basic_latency: got %0d want 5", lat); end
        n_tests++;
        if (bc != 5) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 5", bc); end
        n_tests++;
        if ({pass_a, mm_a, ffv_a} !== {1'b1, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_status: got pass=%b mm=%0d ffv=%b want 1/0/0", pass_a, mm_a, ffv_a);
        end
        n_tests++;
        if (dut_in_a !== 50'h1_0000_0000) begin
            n_fail++; $display("FAIL basic_dut_in_hold: got %h want 1_0000_0000", dut_in_a);
        end
        rd_addr = 4'd0;
        step();
        n_tests++;
        if (rd_data_a !== 30'h0) begin n_fail++; $display("FAIL basic_rd: got %h want 0", rd_data_a); end
        n_tests++;
        if (done_a !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done_a); end
    endtask

    task automatic test_mismatch();
        int lat, bc;
        model_zero = 1'b0;
        for (int i = 0; i < 16; i++) begin
            stim_tab[i] = {20'(i * 37 + 5), 30'(i * 32'h0111_1111 + 32'h2A)};
            gold_tab[i] = model_f(stim_tab[i]) ^ (((i == 3) || (i == 9)) ? 30'h1 : 30'h0);
            load_slot(4'(i), stim_tab[i], gold_tab[i]);
        end
        start_and_wait(5'd16, lat, bc);
        n_tests++;
        if (lat != 65) begin n_fail++; $display("FAIL mm_latency: got %0d want 65", lat); end
        n_tests++;
        if ({pass_a, mm_a, ffi_a, ffv_a} !== {1'b0, 5'd2, 4'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL mm_status: got pass=%b mm=%0d ffi=%0d ffv=%b want 0/2/3/1",
                     pass_a, mm_a, ffi_a, ffv_a);
        end
        rd_addr = 4'd9;
        step();
        n_tests++;
        if (rd_data_a !== model_f(stim_tab[9])) begin
            n_fail++; $display("FAIL mm_rd_slot9: got %h want %h", rd_data_a, model_f(stim_tab[9]));
        end
        rd_addr = 4'd15;
        step();
        n_tests++;
        if (rd_data_a !== model_f(stim_tab[15])) begin
            n_fail++; $display("FAIL mm_rd_slot15: got %h want %h", rd_data_a, model_f(stim_tab[15]));
        end
        idle(20);
    endtask

    task automatic test_ignore_while_busy();
        int lat, bc;
        start = 1'b1; num_vec = 5'd16;
        step();
        start = 1'b0;
        lat = 0;
        while (!done_a && lat < 300) begin
            step();
            lat++;
            if (lat == 10) begin
                start = 1'b1; num_vec = 5'd1;
                ld_we = 1'b1; ld_addr = 4'd0; ld_stim = 50'h3_FFFF_FFFF_FFFF; ld_gold = 30'h5;
            end else begin
                start = 1'b0; ld_we = 1'b0;
            end
        end
        n_tests++;
        if (lat != 65) begin n_fail++; $display("FAIL ign_latency: got %0d want 65", lat); end
        n_tests++;
        if ({pass_a, mm_a, ffi_a, ffv_a} !== {1'b0, 5'd2, 4'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL ign_status: got pass=%b mm=%0d ffi=%0d want 0/2/3", pass_a, mm_a, ffi_a);
        end
        idle(20);
        start_and_wait(5'd1, lat, bc);
        n_tests++;
        if ({pass_a, dut_in_a} !== {1'b1, stim_tab[0]}) begin
            n_fail++;
            $display("FAIL ign_slot0: got pass=%b dut_in=%h want 1/%h", pass_a, dut_in_a, stim_tab[0]);
        end
        rd_addr = 4'd0;
        step();
        n_tests++;
        if (rd_data_a !== model_f(stim_tab[0])) begin
            n_fail++; $display("FAIL ign_rd_slot0: got %h want %h", rd_data_a, model_f(stim_tab[0]));
        end
        idle(5);
    endtask

    task automatic test_bad_start();
        int lat, bc;
        start_and_wait(5'd0, lat, bc);
        n_tests++;
        if ({lat, bc} != {32'd0, 32'd0}) begin
            n_fail++; $display("FAIL bad0_timing: got lat=%0d busy=%0d want 0/0", lat, bc);
        end
        n_tests++;
        if ({pass_a, mm_a} !== 6'd0) begin
            n_fail++; $display("FAIL bad0_status: got pass=%b mm=%0d want 0/0", pass_a, mm_a);
        end
        step();
        n_tests++;
        if ({done_a, busy_a} !== 2'b00) begin
            n_fail++; $display("FAIL bad0_after: got done=%b busy=%b want 0/0", done_a, busy_a);
        end
        start_and_wait(5'd17, lat, bc);
        n_tests++;
        if ({lat, bc} != {32'd0, 32'd0}) begin
            n_fail++; $display("FAIL bad17_timing: got lat=%0d busy=%0d want 0/0", lat, bc);
        end
        n_tests++;
        if ({pass_a, mm_a, busy_a} !== 7'd0) begin
            n_fail++; $display("FAIL bad17_status: got pass=%b mm=%0d busy=%b", pass_a, mm_a, busy_a);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, dones;
        start = 1'b1; num_vec = 5'd16;
        step();
        start = 1'b0;
        idle(21);
        n_tests++;
        if ({busy_a, mm_a, ffv_a} !== {1'b1, 5'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_pre_reset: got busy=%b mm=%0d ffv=%b want 1/1/1", busy_a, mm_a, ffv_a);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if ({busy_a, done_a, mm_a, ffv_a, dut_in_a} !== 58'h0) begin
            n_fail++;
            $display("FAIL mid_post_reset: got busy=%b done=%b mm=%0d ffv=%b dut_in=%h want all 0",
                     busy_a, done_a, mm_a, ffv_a, dut_in_a);
        end
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done_a) dones++;
        end
        n_tests++;
        if (dones != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses want 0", dones); end
        start_and_wait(5'd2, lat, bc);
        n_tests++;
        if (lat != 9) begin n_fail++; $display("FAIL mid_restart_latency: got %0d want 9", lat); end
        n_tests++;
        if ({pass_a, mm_a} !== {1'b1, 5'd0}) begin
            n_fail++; $display("FAIL mid_restart_status: got pass=%b mm=%0d want 1/0", pass_a, mm_a);
        end
        idle(5);
    endtask

    task automatic test_settle_stability();
        int done_at;
        int k;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) load_slot(4'(i), stim_tab[i], gold_tab[i]);
        start = 1'b1; num_vec = 5'd3;
        step();
        start = 1'b0;
        done_at = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c <= 16) begin
                // Vector k is driven from edge 5k+1 through the edge after its capture.
                k = (c - 1) / 5;
                if (k > 2) k = 2;
                n_tests++;
                if (dut_in_b !== stim_tab[k]) begin
                    n_fail++;
                    $display("FAIL settle_dut_in_c%0d: got %h want %h", c, dut_in_b, stim_tab[k]);
                end
            end
            if (done_b && done_at < 0) done_at = c;
        end
        n_tests++;
        if (done_at != 16) begin n_fail++; $display("FAIL settle_latency: got %0d want 16", done_at); end
        n_tests++;
        if ({pass_b, mm_b} !== {1'b1, 5'd0}) begin
            n_fail++; $display("FAIL settle_status: got pass=%b mm=%0d want 1/0", pass_b, mm_b);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_ignore_while_busy();
        test_bad_start();
        test_reset_mid_run();
        test_settle_stability();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
